// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared register-file constants and types for the writeback arbiter
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// rtl/writeback_arbiter_rr_arbiter.sv - round-robin one-hot grant with pointer register
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 enable,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] next_ptr;
  logic          found;
  int            idx;

  // Search from ptr upward with wraparound; next_ptr points just past the winner.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (enable && !found && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        found         = 1'b1;
        next_ptr      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin share of the register-file write port among NUM_SRC producers
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [REG_ADDR_W*NUM_SRC-1:0] src_reg,
  input  logic [DATA_WIDTH*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          wb_stall,
  output logic                          write,
  output logic [REG_ADDR_W-1:0]         write_reg,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [NUM_REGS-1:0]           pending_regs,
  input  logic                          report
);

  logic                       transfer;
  reg_addr_t                  sel_reg;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [$clog2(NUM_SRC)-1:0] rr_ptr;
  logic [31:0]                cycle_count;

  assign transfer = |(src_valid & src_ready);

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (src_valid),
    .enable  (!wb_stall && !reset),
    .advance (transfer),
    .gnt     (src_ready),
    .ptr     (rr_ptr)
  );

  always_comb begin
    sel_reg  = ZERO_REG;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_ready[i]) begin
        sel_reg  = src_reg[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data = src_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // Hazard view of every outstanding result, independent of who wins this cycle.
  always_comb begin
    pending_regs = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        pending_regs = pending_regs | reg_onehot(src_reg[REG_ADDR_W*i +: REG_ADDR_W]);
      end
    end
    pending_regs[0] = 1'b0;
  end

  // x0 results are consumed like any other but never raise the write enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      write      <= 1'b0;
      write_reg  <= ZERO_REG;
      write_data <= '0;
    end else if (transfer) begin
      write      <= (sel_reg != ZERO_REG);
      write_reg  <= sel_reg;
      write_data <= sel_data;
    end else begin
      write      <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
    if (report) begin
      $display("core %0d cycle %0d src_valid %b src_ready %b rr_ptr %0d write %b write_reg %0d write_data %0h",
               CORE, cycle_count, src_valid, src_ready, rr_ptr, write, write_reg, write_data);
    end
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single register-file write port between NUM_SRC result producers (e.g. ALU path, load return, long-latency mul/div unit).
- Each producer offers a valid/ready request carrying a destination register and data.
- The block grants one request per cycle in round-robin order and drives a registered write, write_reg and write_data to the register file.
- Sits between the producers and the register-file write port, replacing the single-source writeback select.

Parameters:
CORE, 0, core index used in report output
DATA_WIDTH, 32, result data width
NUM_SRC, 3, number of requesters; legal range 2..4

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
src_valid  input  NUM_SRC  per-source request valid
src_reg  input  5*NUM_SRC  per-source destination register; source i uses bits [5i+4:5i]
src_data  input  DATA_WIDTH*NUM_SRC  per-source result; source i uses slice i
src_ready  output  NUM_SRC  one-hot grant, combinational
wb_stall  input  1  register-file port unavailable this cycle; blocks all grants
write  output  1  register-file write enable, registered
write_reg  output  5  register-file write address, registered
write_data  output  DATA_WIDTH  register-file write data, registered
pending_regs  output  32  bit r set when any src_valid targets register r; combinational; bit 0 always 0
report  input  1  print per-cycle debug block when high

Behaviour:
- Single clock domain: clock. Reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - write=0, write_reg=0, write_data=0.
  - rr_ptr=0, cycle counter=0.
  - src_ready is all zeros while reset is high.
- Grant rule:
  - Condition: wb_stall=0 and at least one src_valid.
  - Grant the first valid source found searching from rr_ptr upward, modulo NUM_SRC.
  - src_ready is one-hot for the granted source and zero for all others.
  - If wb_stall=1 or no source is valid, src_ready=0.
- Transfer: occurs when src_valid[i] && src_ready[i]. On the next rising edge:
  - write_reg <= src_reg slice i.
  - write_data <= src_data slice i.
  - write <= (src_reg slice i != 0).
  - A write to x0 is accepted and consumed but suppressed.
- Latency: exactly 1 cycle from transfer to write=1 at the register file.
- No-transfer cycle: write <= 0. write_reg and write_data hold their previous values.
- Pointer:
  - On a transfer from source i, rr_ptr <= (i+1) mod NUM_SRC.
  - With no transfer, rr_ptr holds.
  - Guarantees no source waits more than NUM_SRC-1 grants.
- Source protocol:
  - Once src_valid is asserted, the source holds src_valid, src_reg and src_data stable until its transfer.
  - The arbiter does not buffer requests; the source is the buffer.
- Same destination from two sources in one cycle: both are served in arbitration order, and the last-written value wins. Program ordering is the producers' responsibility, enforced via pending_regs in the hazard unit.
- pending_regs:
  - Bitwise OR of one-hot decodes of src_reg for every valid source; bit 0 forced to 0.
  - Purely combinational, with no dependence on grant.
- Reset asserted mid-operation:
  - Any request granted in that cycle is discarded.
  - write is 0 on the following cycle.
  - rr_ptr returns to 0.
- Report:
  - The cycle counter increments every non-reset cycle.
  - When report=1, each rising edge prints CORE, cycle, src_valid, src_ready, rr_ptr, write, write_reg and write_data.

Decomposition:
- Shared package constants: REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=0.
- One natural sub-module, rr_arbiter (parameter N):
  - Inputs: req, enable. Output: one-hot gnt.
  - Holds the pointer register, updated on an advance input.
  - The top level adds the data mux, output registers, x0 suppression, pending_regs decode and the report block.

Test Plan:
1. Reset held 3 cycles with all src_valid=1 -> src_ready=000 throughout; write=0, write_reg=0, write_data=0 after the first edge.
2. Only src0 valid, reg=3, data=5 -> src_ready=001 same cycle; next cycle write=1, write_reg=3, write_data=5; following cycle write=0.
3. All three sources valid continuously (regs 1/2/4, data 10/20/40), withdrawing after grant -> grants in order 0,1,2 on consecutive cycles; write_data sequence 10,20,40 each one cycle after its grant.
4. src1 valid, reg=0, data=7 -> src_ready=010; next cycle write=0, write_reg=0; rr_ptr=2.
5. wb_stall=1 for 2 cycles with src2 valid (reg=9) -> src_ready=000 and pending_regs[9]=1 during the stall; after release, grant src2 and write_reg=9 one cycle later.
6. Reset asserted in the same cycle as a grant to src1 -> no write on the next cycle; rr_ptr=0 after reset.
